// File: rtl/packet_mem_rd_port.sv
// packet_mem_rd_port
//   Single packet buffer between the packet write side (snooper) and the
//   cpu_adapter read side. Writes fill DATA_WIDTH-bit words and a wr_done
//   commits the byte length. The CPU then reads words with a fixed,
//   fully pipelined latency of RD_LAT cycles (1 or 2). An ownership FSM
//   blocks writes while the committed packet is being read.
//
//   Optional build macro: PACKET_MEM_BOUNDS_CHECK_EN
//     When defined, returned bytes whose byte address is >= pkt_len read
//     back as 0x00. The mask is registered alongside the RAM read, so it
//     adds no latency.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   wr_en          write wr_data at wr_addr (taken only when wr_ready=1)
//   wr_addr        write word address
//   wr_data        write word, byte 0 in the MSBs
//   wr_done        packet complete, commits wr_byte_len
//   wr_byte_len    packet length in bytes
//   wr_ready       buffer accepts writes (IDLE or FILL)
//   pkt_rdy        packet committed and readable (READY)
//   pkt_len        committed length
//   rd_done        CPU finished with the packet, releases the buffer
//   rd_en          word read request
//   word_rd_addra  read word address
//   bigword        read data, held while bigword_vld=0
//   bigword_vld    one-cycle strobe marking bigword valid
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | buffer empty, writes accepted
// FILL   | at least one word written, waiting for wr_done
// READY  | packet committed, reads honoured, writes and wr_done ignored

module packet_mem_rd_port #(
  parameter int BYTE_ADDR_WIDTH = 12,
  parameter int ADDR_WIDTH      = 9,
  parameter int RD_LAT          = 2,
  localparam int BYTE_SHIFT     = BYTE_ADDR_WIDTH - ADDR_WIDTH,
  localparam int NUM_BYTES      = 2 ** BYTE_SHIFT,
  localparam int DATA_WIDTH     = NUM_BYTES * 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_done,
  input  logic [BYTE_ADDR_WIDTH:0] wr_byte_len,
  output logic                     wr_ready,
  output logic                     pkt_rdy,
  output logic [BYTE_ADDR_WIDTH:0] pkt_len,
  input  logic                     rd_done,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    word_rd_addra,
  output logic [DATA_WIDTH-1:0]    bigword,
  output logic                     bigword_vld
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic                     wr_accept;
  logic                     done_accept;
  logic                     rd_accept;
  logic [BYTE_ADDR_WIDTH:0] pkt_len_q;

  logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];

  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] s1_word;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_done) begin
          state_d = ST_READY;
        end else if (wr_en) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (wr_done) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (rd_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_ready    = (state_q != ST_READY);
  assign pkt_rdy     = (state_q == ST_READY);
  assign wr_accept   = wr_en & wr_ready;
  assign done_accept = wr_done & wr_ready;
  // A request in the same cycle as rd_done belongs to the released packet.
  assign rd_accept   = rd_en & pkt_rdy & ~rd_done;

  // ------------------------------------------------------ length commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_len_q <= '0;
    end else if (done_accept) begin
      pkt_len_q <= wr_byte_len;
    end
  end

  assign pkt_len = pkt_len_q;

  // ----------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // First read stage: RAM output register plus its valid bit. The data
  // register only moves on an accepted read so bigword holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= rd_accept;
      if (rd_accept) begin
        s1_data <= mem[word_rd_addra];
      end
    end
  end

`ifdef PACKET_MEM_BOUNDS_CHECK_EN
  // keep bit j covers data bits [8j+7:8j]; byte 0 of the word is the MSB
  // byte, so byte k of the word maps to keep bit NUM_BYTES-1-k.
  logic [NUM_BYTES-1:0]     keep_d;
  logic [NUM_BYTES-1:0]     keep_q;
  logic [BYTE_ADDR_WIDTH:0] byte_addr;

  always_comb begin
    keep_d    = '0;
    byte_addr = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      byte_addr = {1'b0, word_rd_addra, BYTE_SHIFT'(k)};
      keep_d[NUM_BYTES-1-k] = (byte_addr < pkt_len_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keep_q <= '0;
    end else if (rd_accept) begin
      keep_q <= keep_d;
    end
  end

  always_comb begin
    s1_word = '0;
    for (int j = 0; j < NUM_BYTES; j++) begin
      s1_word[8*j +: 8] = s1_data[8*j +: 8] & {8{keep_q[j]}};
    end
  end
`else
  assign s1_word = s1_data;
`endif

  // ------------------------------------------------------ output stage
  if (RD_LAT == 1) begin : g_lat1
    assign bigword     = s1_word;
    assign bigword_vld = s1_vld;
  end else begin : g_lat2
    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_data;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_vld  <= 1'b0;
        out_data <= '0;
      end else begin
        out_vld <= s1_vld;
        if (s1_vld) begin
          out_data <= s1_word;
        end
      end
    end

    assign bigword     = out_data;
    assign bigword_vld = out_vld;
  end

endmodule

// File: tb/tb_packet_mem_rd_port.sv
// Scoreboard bench for packet_mem_rd_port. Reads push the expected word and
// the cycle its strobe must appear; a monitor on the falling edge pops and
// compares every bigword_vld strobe. Status outputs are checked directly.

module tb_packet_mem_rd_port;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_done;
  logic [12:0] wr_byte_len;
  logic        wr_ready;
  logic        pkt_rdy;
  logic [12:0] pkt_len;
  logic        rd_done;
  logic        rd_en;
  logic [8:0]  word_rd_addra;
  logic [63:0] bigword;
  logic        bigword_vld;

  always #5 clk = ~clk;

  packet_mem_rd_port #(
    .BYTE_ADDR_WIDTH(12),
    .ADDR_WIDTH     (9),
    .RD_LAT         (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_done      (wr_done),
    .wr_byte_len  (wr_byte_len),
    .wr_ready     (wr_ready),
    .pkt_rdy      (pkt_rdy),
    .pkt_len      (pkt_len),
    .rd_done      (rd_done),
    .rd_en        (rd_en),
    .word_rd_addra(word_rd_addra),
    .bigword      (bigword),
    .bigword_vld  (bigword_vld)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (bigword_vld === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: bigword_vld=1 at cycle %0d bigword=%h, required no strobe",
                 cyc, bigword);
      end else begin
        mon_e = sb.pop_front();
        if (bigword !== mon_e.data || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d",
                   bigword, cyc, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one read request for the current cycle and record its expectation.
  task automatic issue_read(input logic [8:0] addr, input logic [63:0] exp);
    rd_en         = 1'b1;
    word_rd_addra = addr;
    sb.push_back('{data: exp, cyc: cyc + RD_LAT});
  endtask

  function automatic logic [63:0] fill_word(input int i);
    logic [63:0] base;
    logic [63:0] step;
    base = 64'h0001020304050607;
    step = 64'h0808080808080808;
    return base + 64'(i) * step;
  endfunction

  logic [63:0] exp_d5;
  logic [63:0] exp_len13_a1;
  logic [63:0] exp_len13_a2;
  logic [63:0] exp_len0_a0;

  initial begin
`ifdef PACKET_MEM_BOUNDS_CHECK_EN
    exp_d5       = 64'hDEADBEEF00000000;
    exp_len13_a1 = 64'h08090A0B0C000000;
    exp_len13_a2 = 64'h0000000000000000;
    exp_len0_a0  = 64'h0000000000000000;
`else
    exp_d5       = 64'hDEADBEEF01234567;
    exp_len13_a1 = 64'h08090A0B0C0D0E0F;
    exp_len13_a2 = 64'h1011121314151617;
    exp_len0_a0  = 64'h0001020304050607;
`endif

    rst = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0; wr_byte_len = '0;
    rd_done = 1'b0; rd_en = 1'b0; word_rd_addra = '0;
    ticks(2);
    check("reset_wr_ready", 64'(wr_ready), 64'd1);
    check("reset_pkt_rdy", 64'(pkt_rdy), 64'd0);
    check("reset_pkt_len", 64'(pkt_len), 64'd0);
    check("reset_bigword", bigword, 64'd0);
    check("reset_vld", 64'(bigword_vld), 64'd0);
    rst = 1'b1;
    tick();

    // Read request while IDLE must not strobe.
    rd_en = 1'b1; word_rd_addra = 9'd0;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < RD_LAT + 1; i++) begin
      tick();
      check("idle_read_no_vld", 64'(bigword_vld), 64'd0);
    end

    // Fill words 0..3 and commit 32 bytes.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 9'(i); wr_data = fill_word(i);
      tick();
      if (i == 0) check("fill_wr_ready", 64'(wr_ready), 64'd1);
    end
    wr_en = 1'b0; wr_done = 1'b1; wr_byte_len = 13'd32;
    tick();
    wr_done = 1'b0;
    check("commit_pkt_rdy", 64'(pkt_rdy), 64'd1);
    check("commit_pkt_len", 64'(pkt_len), 64'd32);
    check("commit_wr_ready", 64'(wr_ready), 64'd0);

    for (int i = 0; i < 4; i++) begin
      issue_read(9'(i), fill_word(i));
      tick();
    end
    rd_en = 1'b0;
    ticks(RD_LAT + 2);

    // Writes and wr_done in READY are ignored.
    wr_en = 1'b1; wr_addr = 9'd0; wr_data = 64'hFFFFFFFFFFFFFFFF;
    wr_done = 1'b1; wr_byte_len = 13'd5;
    tick();
    wr_en = 1'b0; wr_done = 1'b0;
    check("own_wr_ready", 64'(wr_ready), 64'd0);
    check("own_pkt_len_held", 64'(pkt_len), 64'd32);
    issue_read(9'd0, 64'h0001020304050607);
    tick();
    rd_en = 1'b0;
    ticks(RD_LAT + 2);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("release_wr_ready", 64'(wr_ready), 64'd1);
    check("release_pkt_rdy", 64'(pkt_rdy), 64'd0);

    // Write and commit in the same cycle, then read it back immediately.
    wr_en = 1'b1; wr_addr = 9'd5; wr_data = 64'hDEADBEEF01234567;
    wr_done = 1'b1; wr_byte_len = 13'd44;
    tick();
    wr_en = 1'b0; wr_done = 1'b0;
    check("simul_pkt_rdy", 64'(pkt_rdy), 64'd1);
    check("simul_pkt_len", 64'(pkt_len), 64'd44);
    issue_read(9'd5, exp_d5);
    tick();
    issue_read(9'd1, 64'h08090A0B0C0D0E0F);
    tick();

    // rd_done right after a read: that read completes, the one beside
    // rd_done is dropped.
    word_rd_addra = 9'd2;
    rd_en = 1'b1;
    rd_done = 1'b1;
    tick();
    rd_en = 1'b0; rd_done = 1'b0;
    ticks(RD_LAT + 2);
    check("late_done_pkt_rdy", 64'(pkt_rdy), 64'd0);

    // Zero-length packet.
    wr_done = 1'b1; wr_byte_len = 13'd0;
    tick();
    wr_done = 1'b0;
    check("zero_len_pkt_rdy", 64'(pkt_rdy), 64'd1);
    check("zero_len_pkt_len", 64'(pkt_len), 64'd0);
    issue_read(9'd0, exp_len0_a0);
    tick();
    rd_en = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    ticks(RD_LAT + 1);

    // 13-byte packet over the existing words 1 and 2.
    wr_done = 1'b1; wr_byte_len = 13'd13;
    tick();
    wr_done = 1'b0;
    issue_read(9'd1, exp_len13_a1);
    tick();
    issue_read(9'd2, exp_len13_a2);
    tick();
    rd_en = 1'b0;
    ticks(RD_LAT + 2);

    // Reset while a read is in flight: no strobe survives.
    rd_en = 1'b1; word_rd_addra = 9'd3;
    tick();
    rd_en = 1'b0;
    rst = 1'b0;
    ticks(2);
    check("rst_mid_vld", 64'(bigword_vld), 64'd0);
    check("rst_mid_bigword", bigword, 64'd0);
    check("rst_mid_pkt_rdy", 64'(pkt_rdy), 64'd0);
    check("rst_mid_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_mid_pkt_len", 64'(pkt_len), 64'd0);
    rst = 1'b1;
    ticks(RD_LAT + 2);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
